memwb_stage: RTL and testbench
==============================

// Module: memwb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback stage; consumes mem_unit outputs, drives register-file write port.
//  Holds its contents while MEM_BUSYWAIT stalls the pipe, so mem_fwd_unit keeps a stable forwarding source.
//  Selects the writeback value, suppresses x0 writes, and counts retired instructions and stall cycles.
// PARAMETERS
//  DATA_WIDTH  32  width of ALU_RESULT, READ_DATA, PC_4 and writeback data
//  CNT_WIDTH   32  width of the INSTRET_CNT and STALL_CNT counters
// PORTS
//  CLK                  in   1           clock, rising edge
//  RESET                in   1           asynchronous, active-high reset
//  MEM_BUSYWAIT         in   1           cache busy; pipeline stalled
//  FLUSH                in   1           kill the MEM-stage instruction (loads a bubble)
//  REG_WRITE_EN_MEM     in   1           instruction in MEM writes a register
//  WB_VALUE_SEL_MEM     in   2           00 ALU, 01 load data, 10 PC+4, 11 reserved
//  MEM_READ_EN_MEM      in   1           instruction in MEM is a load
//  PC_4_MEM             in   DATA_WIDTH  PC+4 of MEM instruction
//  ALU_RESULT           in   DATA_WIDTH  ALU result of MEM instruction
//  READ_DATA            in   DATA_WIDTH  load data, already extended by cache controller
//  REG_WRITE_ADDR_MEM   in   5           destination register
//  REG_WRITE_EN_WB      out  1           register-file write strobe
//  REG_WRITE_ADDR_WB    out  5           register-file write address
//  Wb_Select_Mux_Out    out  DATA_WIDTH  writeback data (regfile write + forwarding)
//  MEM_READ_EN_WB       out  1           WB instruction is a load (to mem_fwd_unit)
//  WB_VALID             out  1           WB register holds a real instruction
//  INSTRET_CNT          out  CNT_WIDTH   retired-instruction count
//  STALL_CNT            out  CNT_WIDTH   cycles with MEM_BUSYWAIT high
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stall): all registers, outputs and counters to 0; WB_VALID=0.
//  - Registered fields: valid, wr_en, sel, rd_en, addr, pc4, alu, rdata, plus a 'fresh' flag.
//  - Capture rule per rising edge, priority order:
//    1. MEM_BUSYWAIT=1: hold all fields; fresh<=0.
//    2. FLUSH=1: load bubble: valid=0, wr_en=0, rd_en=0, addr=0, data fields 0; fresh<=0.
//    3. else: load MEM inputs; valid<=1; fresh<=1.
//  - Busywait beats FLUSH: a flush during a stall is ignored; the front end re-asserts it.
//  - Latency: one cycle, MEM inputs to WB outputs.
//  - Wb_Select_Mux_Out (comb from regs): 00 alu, 01 rdata, 10 pc4, 11 zero.
//  - REG_WRITE_EN_WB = valid & fresh & wr_en & (addr!=0) & (sel!=11): one pulse per instruction,
//    never repeated while held.
//  - REG_WRITE_ADDR_WB, MEM_READ_EN_WB: registered values, stable through stalls for forwarding.
//    MEM_READ_EN_WB is forced 0 when valid=0.
//  - INSTRET_CNT += 1 each cycle with valid & fresh, counting x0 and non-writing instructions.
//  - STALL_CNT += 1 each cycle with MEM_BUSYWAIT=1.
//  - Both counters wrap modulo 2^CNT_WIDTH, no saturation.
//  - A cycle that retires and stalls bumps both counters.
//  - sel=11 with wr_en=1: no write; the instruction still retires.
// TESTING
//  1. ALU op: sel=00, ALU_RESULT=0x1234, addr=5, wr_en=1 -> next cycle: strobe 1 cycle, data 0x1234,
//     addr 5, INSTRET_CNT=1.
//  2. Load then 3-cycle busywait: sel=01, READ_DATA=0xFFFFFF80, addr=7 ->
//     - WB strobe exactly once;
//     - addr 7 and MEM_READ_EN_WB=1 held all 3 cycles;
//     - STALL_CNT=3, INSTRET_CNT +1.
//  3. JAL: sel=10, PC_4_MEM=0x104, addr=1 -> data 0x104, strobe 1; same with addr=0 -> strobe 0,
//     INSTRET_CNT still +1.
//  4. FLUSH=1 with a valid ALU op -> WB_VALID=0, strobe 0, MEM_READ_EN_WB=0, counter unchanged;
//     FLUSH and BUSYWAIT together -> hold.
//  5. RESET asserted mid-stall, between clock edges -> all outputs 0 immediately;
//     first post-reset instruction retires normally.
//  6. Preload INSTRET_CNT to 0xFFFFFFFF via 2^32-1 retirements (or force) -> next retire wraps to 0.

Source files
------------

// File: rtl/memwb_if.sv
// ---------------------------------------------------------------------------
// memwb_if
//   Bundle between the MEM stage and the MEM/WB pipeline register.
//
//   MEM-side inputs (driven by the master, consumed by memwb_stage):
//     MEM_BUSYWAIT        cache busy, pipeline stalled
//     FLUSH               kill the MEM-stage instruction
//     REG_WRITE_EN_MEM    instruction in MEM writes a register
//     WB_VALUE_SEL_MEM    00 ALU, 01 load data, 10 PC+4, 11 reserved
//     MEM_READ_EN_MEM     instruction in MEM is a load
//     PC_4_MEM            PC+4 of the MEM instruction
//     ALU_RESULT          ALU result of the MEM instruction
//     READ_DATA           load data, already extended by the cache controller
//     REG_WRITE_ADDR_MEM  destination register
//
//   WB-side outputs (driven by memwb_stage):
//     REG_WRITE_EN_WB     register-file write strobe
//     REG_WRITE_ADDR_WB   register-file write address
//     Wb_Select_Mux_Out   writeback data (regfile write + forwarding)
//     MEM_READ_EN_WB      WB instruction is a load
//     WB_VALID            WB register holds a real instruction
//     INSTRET_CNT         retired-instruction count
//     STALL_CNT           cycles with MEM_BUSYWAIT high
// ---------------------------------------------------------------------------
interface memwb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  MEM_BUSYWAIT;
    logic                  FLUSH;
    logic                  REG_WRITE_EN_MEM;
    logic [1:0]            WB_VALUE_SEL_MEM;
    logic                  MEM_READ_EN_MEM;
    logic [DATA_WIDTH-1:0] PC_4_MEM;
    logic [DATA_WIDTH-1:0] ALU_RESULT;
    logic [DATA_WIDTH-1:0] READ_DATA;
    logic [4:0]            REG_WRITE_ADDR_MEM;

    logic                  REG_WRITE_EN_WB;
    logic [4:0]            REG_WRITE_ADDR_WB;
    logic [DATA_WIDTH-1:0] Wb_Select_Mux_Out;
    logic                  MEM_READ_EN_WB;
    logic                  WB_VALID;
    logic [CNT_WIDTH-1:0]  INSTRET_CNT;
    logic [CNT_WIDTH-1:0]  STALL_CNT;

    // MEM stage side: drives the instruction, observes the WB results.
    modport master (
        output MEM_BUSYWAIT, FLUSH, REG_WRITE_EN_MEM, WB_VALUE_SEL_MEM,
               MEM_READ_EN_MEM, PC_4_MEM, ALU_RESULT, READ_DATA,
               REG_WRITE_ADDR_MEM,
        input  REG_WRITE_EN_WB, REG_WRITE_ADDR_WB, Wb_Select_Mux_Out,
               MEM_READ_EN_WB, WB_VALID, INSTRET_CNT, STALL_CNT
    );

    // MEM/WB register side.
    modport slave (
        input  MEM_BUSYWAIT, FLUSH, REG_WRITE_EN_MEM, WB_VALUE_SEL_MEM,
               MEM_READ_EN_MEM, PC_4_MEM, ALU_RESULT, READ_DATA,
               REG_WRITE_ADDR_MEM,
        output REG_WRITE_EN_WB, REG_WRITE_ADDR_WB, Wb_Select_Mux_Out,
               MEM_READ_EN_WB, WB_VALID, INSTRET_CNT, STALL_CNT
    );
endinterface

// File: rtl/memwb_stage.sv
// ---------------------------------------------------------------------------
// memwb_stage
//   MEM/WB pipeline register plus writeback stage. Captures the MEM-stage
//   instruction, holds it while the cache stalls the pipe (so the forwarding
//   unit keeps a stable source), selects the writeback value, suppresses
//   writes to x0 and counts retired instructions and stall cycles.
//
//   Ports:
//     CLK    rising-edge clock
//     RESET  asynchronous, active-high reset (clears every register)
//     bus    memwb_if.slave: MEM-stage inputs, WB-stage outputs
//
//   Latency: one cycle from MEM inputs to WB outputs.
// ---------------------------------------------------------------------------
module memwb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic    CLK,
    input  logic    RESET,
    memwb_if.slave  bus
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    // Writeback value select; the reserved encoding yields zero.
    function automatic logic [DATA_WIDTH-1:0] wb_mux(
        input logic [1:0]            sel,
        input logic [DATA_WIDTH-1:0] alu,
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [DATA_WIDTH-1:0] pc4
    );
        logic [DATA_WIDTH-1:0] res;
        case (sel)
            SEL_ALU:  res = alu;
            SEL_LOAD: res = rdata;
            SEL_PC4:  res = pc4;
            default:  res = '0;
        endcase
        return res;
    endfunction

    // Modulo-2^CNT_WIDTH increment; wraps rather than saturating.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc(
        input logic [CNT_WIDTH-1:0] cnt
    );
        return cnt + CNT_WIDTH'(1);
    endfunction

    // ---- MEM -> WB register (p1) ----
    logic                  vld_p1;
    logic                  fresh_p1;
    logic                  wr_en_p1;
    logic [1:0]            sel_p1;
    logic                  rd_en_p1;
    logic [4:0]            addr_p1;
    logic [DATA_WIDTH-1:0] pc4_p1;
    logic [DATA_WIDTH-1:0] alu_p1;
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic [CNT_WIDTH-1:0]  instret_cnt_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;

    // Priority: stall holds everything (a flush during a stall is dropped,
    // the front end re-asserts it), then flush loads a bubble, else capture.
    // 'fresh' is only set on the capture edge so the write strobe fires once
    // per instruction even when the register is held for several cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p1   <= 1'b0;
            fresh_p1 <= 1'b0;
            wr_en_p1 <= 1'b0;
            sel_p1   <= SEL_ALU;
            rd_en_p1 <= 1'b0;
            addr_p1  <= '0;
            pc4_p1   <= '0;
            alu_p1   <= '0;
            rdata_p1 <= '0;
        end else if (bus.MEM_BUSYWAIT) begin
            fresh_p1 <= 1'b0;
        end else if (bus.FLUSH) begin
            vld_p1   <= 1'b0;
            fresh_p1 <= 1'b0;
            wr_en_p1 <= 1'b0;
            sel_p1   <= SEL_ALU;
            rd_en_p1 <= 1'b0;
            addr_p1  <= '0;
            pc4_p1   <= '0;
            alu_p1   <= '0;
            rdata_p1 <= '0;
        end else begin
            vld_p1   <= 1'b1;
            fresh_p1 <= 1'b1;
            wr_en_p1 <= bus.REG_WRITE_EN_MEM;
            sel_p1   <= bus.WB_VALUE_SEL_MEM;
            rd_en_p1 <= bus.MEM_READ_EN_MEM;
            addr_p1  <= bus.REG_WRITE_ADDR_MEM;
            pc4_p1   <= bus.PC_4_MEM;
            alu_p1   <= bus.ALU_RESULT;
            rdata_p1 <= bus.READ_DATA;
        end
    end

    // The retire count is bumped on the capture edge so that it already
    // includes the instruction during the cycle it sits fresh in WB; every
    // capture retires exactly once, including x0 and non-writing ops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            instret_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (bus.MEM_BUSYWAIT)
                stall_cnt_q <= cnt_inc(stall_cnt_q);
            if (!bus.MEM_BUSYWAIT && !bus.FLUSH)
                instret_cnt_q <= cnt_inc(instret_cnt_q);
        end
    end

    // ---- WB outputs (combinational from p1) ----
    logic                  wr_strobe;
    logic [DATA_WIDTH-1:0] wb_data;

    always_comb begin
        wr_strobe = vld_p1 & fresh_p1 & wr_en_p1 &
                    (addr_p1 != 5'd0) & (sel_p1 != SEL_RSVD);
        wb_data   = wb_mux(sel_p1, alu_p1, rdata_p1, pc4_p1);
    end

    assign bus.REG_WRITE_EN_WB   = wr_strobe;
    assign bus.REG_WRITE_ADDR_WB = addr_p1;
    assign bus.Wb_Select_Mux_Out = wb_data;
    assign bus.MEM_READ_EN_WB    = vld_p1 & rd_en_p1;
    assign bus.WB_VALID          = vld_p1;
    assign bus.INSTRET_CNT       = instret_cnt_q;
    assign bus.STALL_CNT         = stall_cnt_q;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    logic CLK;
    logic RESET;

    memwb_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) mif ();
    memwb_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  sif ();

    memwb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (mif.slave)
    );

    // Narrow-counter copy, fed the same stimulus, to exercise counter wrap.
    memwb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_w (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (sif.slave)
    );

    assign sif.MEM_BUSYWAIT       = mif.MEM_BUSYWAIT;
    assign sif.FLUSH              = mif.FLUSH;
    assign sif.REG_WRITE_EN_MEM   = mif.REG_WRITE_EN_MEM;
    assign sif.WB_VALUE_SEL_MEM   = mif.WB_VALUE_SEL_MEM;
    assign sif.MEM_READ_EN_MEM    = mif.MEM_READ_EN_MEM;
    assign sif.PC_4_MEM           = mif.PC_4_MEM;
    assign sif.ALU_RESULT         = mif.ALU_RESULT;
    assign sif.READ_DATA          = mif.READ_DATA;
    assign sif.REG_WRITE_ADDR_MEM = mif.REG_WRITE_ADDR_MEM;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: the instruction currently held in WB ----
    typedef struct {
        bit          valid;
        bit          fresh;
        bit          we;
        bit [1:0]    sel;
        bit          rd;
        bit [4:0]    addr;
        bit [31:0]   pc4;
        bit [31:0]   alu;
        bit [31:0]   rdata;
    } slot_t;

    slot_t       m;
    longint      m_retired;
    longint      m_stalls;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.fresh = 0; s.we = 0; s.sel = 0; s.rd = 0;
        s.addr = 0; s.pc4 = 0; s.alu = 0; s.rdata = 0;
        return s;
    endfunction

    task automatic model_reset();
        m = empty_slot();
        m_retired = 0;
        m_stalls  = 0;
    endtask

    task automatic model_edge();
        if (RESET) begin
            model_reset();
        end else if (mif.MEM_BUSYWAIT) begin
            m_stalls++;
            m.fresh = 0;
        end else if (mif.FLUSH) begin
            m = empty_slot();
        end else begin
            m.valid = 1; m.fresh = 1;
            m.we    = mif.REG_WRITE_EN_MEM;
            m.sel   = mif.WB_VALUE_SEL_MEM;
            m.rd    = mif.MEM_READ_EN_MEM;
            m.addr  = mif.REG_WRITE_ADDR_MEM;
            m.pc4   = mif.PC_4_MEM;
            m.alu   = mif.ALU_RESULT;
            m.rdata = mif.READ_DATA;
            m_retired++;
        end
    endtask

    function automatic bit [31:0] exp_data();
        case (m.sel)
            2'd0:    return m.alu;
            2'd1:    return m.rdata;
            2'd2:    return m.pc4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all();
        bit exp_we;
        exp_we = m.valid && m.fresh && m.we && (m.addr != 0) && (m.sel != 2'd3);
        chk("we",      64'(mif.REG_WRITE_EN_WB),   64'(exp_we));
        chk("addr",    64'(mif.REG_WRITE_ADDR_WB), 64'(m.addr));
        chk("data",    64'(mif.Wb_Select_Mux_Out), 64'(exp_data()));
        chk("rden",    64'(mif.MEM_READ_EN_WB),    64'(m.valid && m.rd));
        chk("valid",   64'(mif.WB_VALID),          64'(m.valid));
        chk("instret", 64'(mif.INSTRET_CNT),       64'(m_retired % 64'h1_0000_0000));
        chk("stall",   64'(mif.STALL_CNT),         64'(m_stalls % 64'h1_0000_0000));
        chk("instret_w", 64'(sif.INSTRET_CNT),     64'(m_retired % 16));
        chk("stall_w",   64'(sif.STALL_CNT),       64'(m_stalls % 16));
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked
    // 1 time unit after the edge.
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit busy, input bit flush, input bit we, input bit [1:0] sel,
                         input bit rd, input bit [31:0] pc4, input bit [31:0] alu,
                         input bit [31:0] rdata, input bit [4:0] addr);
        mif.MEM_BUSYWAIT       = busy;
        mif.FLUSH              = flush;
        mif.REG_WRITE_EN_MEM   = we;
        mif.WB_VALUE_SEL_MEM   = sel;
        mif.MEM_READ_EN_MEM    = rd;
        mif.PC_4_MEM           = pc4;
        mif.ALU_RESULT         = alu;
        mif.READ_DATA          = rdata;
        mif.REG_WRITE_ADDR_MEM = addr;
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sync_reset();
        RESET = 1;
        idle();
        cycle();
        cycle();
        RESET = 0;
    endtask

    longint r0, s0;
    int     strobes;

    initial begin
        RESET = 1;
        model_reset();
        idle();
        #1;
        check_all();
        sync_reset();
        chk("rst_instret", 64'(mif.INSTRET_CNT), 64'd0);
        chk("rst_valid",   64'(mif.WB_VALID),    64'd0);

        // 1. ALU op
        drive(0, 0, 1, 2'b00, 0, 32'h100, 32'h1234, 32'h0, 5);
        cycle();
        chk("t1_we",      64'(mif.REG_WRITE_EN_WB),   64'd1);
        chk("t1_data",    64'(mif.Wb_Select_Mux_Out), 64'h1234);
        chk("t1_addr",    64'(mif.REG_WRITE_ADDR_WB), 64'd5);
        chk("t1_instret", 64'(mif.INSTRET_CNT),       64'd1);
        idle();
        cycle();
        chk("t1_we_off",  64'(mif.REG_WRITE_EN_WB),   64'd0);

        // 2. load then 3-cycle busywait
        r0 = m_retired; s0 = m_stalls; strobes = 0;
        drive(0, 0, 1, 2'b01, 1, 32'h200, 32'h55, 32'hFFFF_FF80, 7);
        cycle();
        strobes += int'(mif.REG_WRITE_EN_WB);
        chk("t2_data", 64'(mif.Wb_Select_Mux_Out), 64'hFFFF_FF80);
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 1, 1, 2'b00, 0, $urandom, $urandom, $urandom, 5'($urandom));
            cycle();
            strobes += int'(mif.REG_WRITE_EN_WB);
            chk("t2_addr_hold", 64'(mif.REG_WRITE_ADDR_WB), 64'd7);
            chk("t2_rden_hold", 64'(mif.MEM_READ_EN_WB),    64'd1);
        end
        chk("t2_strobes", 64'(strobes), 64'd1);
        chk("t2_stall",   64'(mif.STALL_CNT),   64'(s0 + 3));
        chk("t2_instret", 64'(mif.INSTRET_CNT), 64'(r0 + 1));
        idle();
        cycle();

        // 3. JAL, then JAL to x0
        drive(0, 0, 1, 2'b10, 0, 32'h104, 32'hDEAD, 32'hBEEF, 1);
        cycle();
        chk("t3_data", 64'(mif.Wb_Select_Mux_Out), 64'h104);
        chk("t3_we",   64'(mif.REG_WRITE_EN_WB),   64'd1);
        r0 = m_retired;
        drive(0, 0, 1, 2'b10, 0, 32'h104, 32'hDEAD, 32'hBEEF, 0);
        cycle();
        chk("t3_x0_we",      64'(mif.REG_WRITE_EN_WB), 64'd0);
        chk("t3_x0_instret", 64'(mif.INSTRET_CNT),     64'(r0 + 1));

        // reserved select with write enable: no write, still retires
        drive(0, 0, 1, 2'b11, 0, 32'h1, 32'h2, 32'h3, 9);
        cycle();
        chk("rsvd_we",   64'(mif.REG_WRITE_EN_WB),   64'd0);
        chk("rsvd_data", 64'(mif.Wb_Select_Mux_Out), 64'd0);

        // 4. flush kills a valid op; flush+busy holds
        r0 = m_retired;
        drive(0, 1, 1, 2'b00, 1, 32'h0, 32'h777, 32'h0, 3);
        cycle();
        chk("t4_valid",   64'(mif.WB_VALID),        64'd0);
        chk("t4_we",      64'(mif.REG_WRITE_EN_WB), 64'd0);
        chk("t4_rden",    64'(mif.MEM_READ_EN_WB),  64'd0);
        chk("t4_instret", 64'(mif.INSTRET_CNT),     64'(r0));
        drive(0, 0, 1, 2'b00, 1, 32'h0, 32'h999, 32'h0, 9);
        cycle();
        drive(1, 1, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0);
        cycle();
        chk("t4_hold_valid", 64'(mif.WB_VALID),          64'd1);
        chk("t4_hold_addr",  64'(mif.REG_WRITE_ADDR_WB), 64'd9);
        chk("t4_hold_data",  64'(mif.Wb_Select_Mux_Out), 64'h999);

        // 5. reset mid-stall, between edges
        cycle();
        #3;
        RESET = 1;
        #1;
        model_reset();
        chk("t5_valid",   64'(mif.WB_VALID),          64'd0);
        chk("t5_addr",    64'(mif.REG_WRITE_ADDR_WB), 64'd0);
        chk("t5_data",    64'(mif.Wb_Select_Mux_Out), 64'd0);
        chk("t5_stall",   64'(mif.STALL_CNT),         64'd0);
        chk("t5_instret", 64'(mif.INSTRET_CNT),       64'd0);
        check_all();
        @(negedge CLK);
        RESET = 0;
        drive(0, 0, 1, 2'b00, 0, 32'h0, 32'hCAFE, 32'h0, 12);
        cycle();
        chk("t5_post_we",      64'(mif.REG_WRITE_EN_WB), 64'd1);
        chk("t5_post_instret", 64'(mif.INSTRET_CNT),     64'd1);

        // 6. counter wrap on the narrow copy
        sync_reset();
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 1, 2'b00, 0, 32'h0, 32'(i), 32'h0, 2);
            cycle();
        end
        chk("t6_w15", 64'(sif.INSTRET_CNT), 64'd15);
        drive(0, 0, 1, 2'b00, 0, 32'h0, 32'h1, 32'h0, 2);
        cycle();
        chk("t6_wrap",   64'(sif.INSTRET_CNT), 64'd0);
        chk("t6_wide16", 64'(mif.INSTRET_CNT), 64'd16);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, 2'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                @(negedge CLK);
                #2;
                RESET = 1;
                #1;
                model_reset();
                check_all();
                @(negedge CLK);
                RESET = 0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
